// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution and an instruction counter.
// Optional forwarding-match outputs are added when FORWARD_EN is defined.
module ex_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        ValidIn,
  input  logic [31:0] ALUResultIn,
  input  logic        ZeroIn,
  input  logic [31:0] WriteDataIn,
  input  logic [4:0]  WriteRegIn,
  input  logic        RegWriteIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        MemtoRegIn,
  input  logic        BranchEQIn,
  input  logic        BranchNEIn,
  input  logic [31:0] BranchTargetIn,
  output logic        ValidOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] WriteDataOut,
  output logic [4:0]  WriteRegOut,
  output logic        RegWriteOut,
  output logic        MemReadOut,
  output logic        MemWriteOut,
  output logic        MemtoRegOut,
  output logic        PCSrc,
  output logic [31:0] BranchTargetOut,
  output logic [31:0] InstrCount
`ifdef FORWARD_EN
  ,
  input  logic [4:0]  RsEX,
  input  logic [4:0]  RtEX,
  output logic        ForwardAMatch,
  output logic        ForwardBMatch,
  output logic [31:0] ForwardValue
`endif
);

  logic taken;
  logic reg_wr;
  logic mem_wr;
  logic branch_q;
  logic TakenUsed;

  always_comb begin
    taken  = ValidIn & ((BranchEQIn & ZeroIn) |
                        (BranchNEIn & ~ZeroIn));
    reg_wr = RegWriteIn & (WriteRegIn != 5'd0);
    mem_wr = MemWriteIn & ~MemReadIn;
  end

  always_ff @(posedge clk) begin
    if (reset || Flush) begin
      ValidOut        <= 1'b0;
      ALUResultOut    <= 32'd0;
      WriteDataOut    <= 32'd0;
      WriteRegOut     <= 5'd0;
      RegWriteOut     <= 1'b0;
      MemReadOut      <= 1'b0;
      MemWriteOut     <= 1'b0;
      MemtoRegOut     <= 1'b0;
      PCSrc           <= 1'b0;
      BranchTargetOut <= 32'd0;
      branch_q        <= 1'b0;
      TakenUsed       <= 1'b0;
      if (reset)
        InstrCount <= 32'd0;
    end else if (Stall) begin
      // A held taken branch has already redirected fetch once.
      PCSrc     <= branch_q & ~TakenUsed;
      TakenUsed <= TakenUsed | branch_q;
    end else if (ValidIn) begin
      ValidOut        <= 1'b1;
      ALUResultOut    <= ALUResultIn;
      WriteDataOut    <= WriteDataIn;
      WriteRegOut     <= WriteRegIn;
      RegWriteOut     <= reg_wr;
      MemReadOut      <= MemReadIn;
      MemWriteOut     <= mem_wr;
      MemtoRegOut     <= MemtoRegIn;
      PCSrc           <= taken;
      BranchTargetOut <= BranchTargetIn;
      branch_q        <= taken;
      TakenUsed       <= taken;
      InstrCount      <= InstrCount + 32'd1;
    end else begin
      ValidOut        <= 1'b0;
      ALUResultOut    <= 32'd0;
      WriteDataOut    <= 32'd0;
      WriteRegOut     <= 5'd0;
      RegWriteOut     <= 1'b0;
      MemReadOut      <= 1'b0;
      MemWriteOut     <= 1'b0;
      MemtoRegOut     <= 1'b0;
      PCSrc           <= 1'b0;
      BranchTargetOut <= 32'd0;
      branch_q        <= 1'b0;
      TakenUsed       <= 1'b0;
    end
  end

`ifdef FORWARD_EN
  logic fwd_ok;

  always_comb begin
    fwd_ok = ValidOut & RegWriteOut & ~MemtoRegOut &
             (WriteRegOut != 5'd0);
    ForwardAMatch = fwd_ok & (WriteRegOut == RsEX);
    ForwardBMatch = fwd_ok & (WriteRegOut == RtEX);
    ForwardValue  = ALUResultOut;
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with a scoreboard queue of
// expected register contents, compared one cycle after each drive.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset, Stall, Flush, ValidIn, ZeroIn;
  logic [31:0] ALUResultIn, WriteDataIn, BranchTargetIn;
  logic [4:0]  WriteRegIn;
  logic        RegWriteIn, MemReadIn, MemWriteIn, MemtoRegIn;
  logic        BranchEQIn, BranchNEIn;
  logic        ValidOut, RegWriteOut, MemReadOut;
  logic        MemWriteOut, MemtoRegOut, PCSrc;
  logic [31:0] ALUResultOut, WriteDataOut;
  logic [31:0] BranchTargetOut, InstrCount;
  logic [4:0]  WriteRegOut;
`ifdef FORWARD_EN
  logic [4:0]  RsEX, RtEX;
  logic        ForwardAMatch, ForwardBMatch;
  logic [31:0] ForwardValue;
`endif

  typedef struct packed {
    logic        v;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw, mr, mw, m2r, pc;
    logic [31:0] bt;
    logic [31:0] cnt;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
    .ValidIn(ValidIn), .ALUResultIn(ALUResultIn),
    .ZeroIn(ZeroIn), .WriteDataIn(WriteDataIn),
    .WriteRegIn(WriteRegIn), .RegWriteIn(RegWriteIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .MemtoRegIn(MemtoRegIn), .BranchEQIn(BranchEQIn),
    .BranchNEIn(BranchNEIn), .BranchTargetIn(BranchTargetIn),
    .ValidOut(ValidOut), .ALUResultOut(ALUResultOut),
    .WriteDataOut(WriteDataOut), .WriteRegOut(WriteRegOut),
    .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut),
    .MemWriteOut(MemWriteOut), .MemtoRegOut(MemtoRegOut),
    .PCSrc(PCSrc), .BranchTargetOut(BranchTargetOut),
    .InstrCount(InstrCount)
`ifdef FORWARD_EN
    ,
    .RsEX(RsEX), .RtEX(RtEX),
    .ForwardAMatch(ForwardAMatch),
    .ForwardBMatch(ForwardBMatch),
    .ForwardValue(ForwardValue)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, want);
  endtask

  task automatic idle();
    reset = 0; Stall = 0; Flush = 0; ValidIn = 0;
    ZeroIn = 0; ALUResultIn = 0; WriteDataIn = 0;
    BranchTargetIn = 0; WriteRegIn = 0; RegWriteIn = 0;
    MemReadIn = 0; MemWriteIn = 0; MemtoRegIn = 0;
    BranchEQIn = 0; BranchNEIn = 0;
  endtask

  // Reference behaviour for one clock edge.
  task automatic predict();
    logic [31:0] c;
    c = m.cnt;
    if (reset) begin
      m = '0;
    end else if (Flush) begin
      m = '0;
      m.cnt = c;
    end else if (Stall) begin
      m.pc = 1'b0;
    end else if (ValidIn) begin
      m.v   = 1'b1;
      m.alu = ALUResultIn;
      m.wd  = WriteDataIn;
      m.wr  = WriteRegIn;
      m.rw  = RegWriteIn && WriteRegIn != 0;
      m.mr  = MemReadIn;
      m.mw  = MemWriteIn && !MemReadIn;
      m.m2r = MemtoRegIn;
      m.pc  = (BranchEQIn && ZeroIn) ||
              (BranchNEIn && !ZeroIn);
      m.bt  = BranchTargetIn;
      m.cnt = c + 1;
    end else begin
      m = '0;
      m.cnt = c;
    end
  endtask

  task automatic cyc(input string tag);
    exp_t e;
    predict();
    q.push_back(m);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      total++;
      $error("FAIL %s: got empty want entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".valid"}, 32'(ValidOut), 32'(e.v));
      chk({tag, ".alu"}, ALUResultOut, e.alu);
      chk({tag, ".wd"}, WriteDataOut, e.wd);
      chk({tag, ".wr"}, 32'(WriteRegOut), 32'(e.wr));
      chk({tag, ".rw"}, 32'(RegWriteOut), 32'(e.rw));
      chk({tag, ".mr"}, 32'(MemReadOut), 32'(e.mr));
      chk({tag, ".mw"}, 32'(MemWriteOut), 32'(e.mw));
      chk({tag, ".m2r"}, 32'(MemtoRegOut), 32'(e.m2r));
      chk({tag, ".pcsrc"}, 32'(PCSrc), 32'(e.pc));
      chk({tag, ".bt"}, BranchTargetOut, e.bt);
      chk({tag, ".cnt"}, InstrCount, e.cnt);
    end
  endtask

  initial begin
    m = '0;
    idle();
`ifdef FORWARD_EN
    RsEX = 0; RtEX = 0;
`endif
    // Reset with stall and flush also high
    reset = 1; Stall = 1; Flush = 1;
    cyc("reset");
    idle();
    ValidIn = 1; ALUResultIn = 32'h1234;
    WriteRegIn = 8; RegWriteIn = 1;
    cyc("plain");
    chk("plain.cnt1", InstrCount, 32'd1);

    // Taken BEQ then three stall cycles
    idle();
    ValidIn = 1; ZeroIn = 1; BranchEQIn = 1;
    BranchTargetIn = 32'h0040_0020;
    cyc("beq");
    chk("beq.pulse", 32'(PCSrc), 32'd1);
    Stall = 1;
    ValidIn = 0; BranchTargetIn = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) cyc("beq_stall");
    chk("beq.held", BranchTargetOut, 32'h0040_0020);

    // SW held by stall, then stall+flush
    idle();
    ValidIn = 1; MemWriteIn = 1;
    ALUResultIn = 32'h100; WriteDataIn = 32'h55;
    cyc("sw");
    Stall = 1;
    cyc("sw_stall");
    Flush = 1;
    cyc("flush");
    chk("flush.mw", 32'(MemWriteOut), 32'd0);

    // $zero destination and illegal mem controls
    idle();
    ValidIn = 1; WriteRegIn = 0; RegWriteIn = 1;
    cyc("zero_reg");
    idle();
    ValidIn = 1; MemReadIn = 1; MemWriteIn = 1;
    WriteRegIn = 3; RegWriteIn = 1; MemtoRegIn = 1;
    cyc("rd_wr");

    // BNE taken, BNE not taken, both branch bits
    idle();
    ValidIn = 1; BranchNEIn = 1;
    BranchTargetIn = 32'h0040_0100;
    cyc("bne_t");
    ZeroIn = 1;
    cyc("bne_nt");
    BranchEQIn = 1;
    cyc("both");
    ZeroIn = 0;
    cyc("both_z0");

    // Bubble load ignores junk inputs
    idle();
    ALUResultIn = 32'hFFFF_0000; WriteRegIn = 7;
    RegWriteIn = 1; MemWriteIn = 1; BranchEQIn = 1;
    ZeroIn = 1; BranchTargetIn = 32'h1111_2222;
    cyc("bubble");

    // Counter wrap from all ones
    idle();
    force dut.InstrCount = 32'hFFFF_FFFF;
    #1;
    release dut.InstrCount;
    m.cnt = 32'hFFFF_FFFF;
    ValidIn = 1; ALUResultIn = 32'h77;
    cyc("wrap");
    chk("wrap.zero", InstrCount, 32'd0);

    // Reset during a stalled taken branch
    idle();
    ValidIn = 1; ZeroIn = 1; BranchEQIn = 1;
    BranchTargetIn = 32'h0040_0040;
    cyc("rb_load");
    Stall = 1;
    cyc("rb_stall");
    reset = 1;
    cyc("rb_reset");
    reset = 0;
    cyc("rb_after");
    Stall = 0; ValidIn = 0;
    cyc("rb_release");

`ifdef FORWARD_EN
    idle();
    ValidIn = 1; WriteRegIn = 9; RegWriteIn = 1;
    ALUResultIn = 32'hABCD;
    cyc("fwd_load");
    RsEX = 9; RtEX = 9;
    #1;
    chk("fwd.a", 32'(ForwardAMatch), 32'd1);
    chk("fwd.b", 32'(ForwardBMatch), 32'd1);
    chk("fwd.val", ForwardValue, 32'hABCD);
    MemtoRegIn = 1;
    cyc("fwd_m2r");
    chk("fwd.a0", 32'(ForwardAMatch), 32'd0);
    chk("fwd.b0", 32'(ForwardBMatch), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous active-high reset.
- Stall, in, 1: hold all stage contents.
- Flush, in, 1: load a bubble.
- ValidIn, in, 1: EX stage holds a real instruction.
- ALUResultIn, in, 32: ALU result.
- ZeroIn, in, 1: ALU zero flag.
- WriteDataIn, in, 32: rt value for store.
- WriteRegIn, in, 5: destination register.
- RegWriteIn, MemReadIn, MemWriteIn, MemtoRegIn, in, 1 each: EX control bits.
- BranchEQIn, BranchNEIn, in, 1 each: branch type.
- BranchTargetIn, in, 32: computed branch target.
- ValidOut, out, 1: stage holds a real instruction.
- ALUResultOut, out, 32: registered ALU result / memory address.
- WriteDataOut, out, 32: registered store data.
- WriteRegOut, out, 5: registered destination register.
- RegWriteOut, MemReadOut, MemWriteOut, MemtoRegOut, out, 1 each: registered control bits.
- PCSrc, out, 1: branch-taken pulse to fetch.
- BranchTargetOut, out, 32: registered branch target.
- InstrCount, out, 32: count of valid instructions captured.

Function
REQ-003 SHALL update state only on the rising edge of clk, with priority reset > Flush > Stall > load.
REQ-004 On load, SHALL capture all *In data fields into the matching *Out registers, with one cycle of latency.
REQ-005 On load with ValidIn=0, SHALL set ValidOut=0 and clear every control output and PCSrc; data fields are don't-care but SHALL be loaded as 0.
REQ-006 On load with ValidIn=1, SHALL set ValidOut=1 and capture the control bits, with these overrides:
- WriteRegIn=0 forces RegWriteOut=0.
- MemReadIn=MemWriteIn=1 forces MemWriteOut=0, while MemReadOut is kept.
REQ-007 SHALL compute branch-taken as ValidIn & ((BranchEQIn & ZeroIn) | (BranchNEIn & ~ZeroIn)); BranchEQIn=BranchNEIn=1 SHALL yield taken=1.
REQ-008 SHALL assert PCSrc for exactly one cycle, the cycle after a taken branch is loaded, even while Stall holds that instruction; an internal TakenUsed flag SHALL enforce this.
REQ-009 On Flush, SHALL load a bubble: ValidOut=0, all control outputs 0, PCSrc=0, data outputs 0; Flush with Stall SHALL still flush.
REQ-010 On Stall without Flush, SHALL hold every output except PCSrc, which SHALL go to 0 after its single pulse.
REQ-011 SHALL increment InstrCount by 1 on each load with ValidIn=1, wrapping modulo 2^32 from FFFFFFFF to 0; stall and flush cycles SHALL NOT count.

Reset
REQ-012 While reset=1 at a clock edge, SHALL clear all outputs and InstrCount to 0 and clear TakenUsed, regardless of Stall or Flush.
REQ-013 Reset asserted during a stalled or branch-pending instruction SHALL discard it, and no PCSrc pulse SHALL follow.

Configuration
REQ-014 Macro FORWARD_EN, when defined, SHALL add these ports:
- RsEX, in, 5; RtEX, in, 5.
- ForwardAMatch, out, 1; ForwardBMatch, out, 1.
- ForwardValue, out, 32, equal to ALUResultOut.
REQ-015 With FORWARD_EN defined, ForwardAMatch SHALL be the combinational value ValidOut & RegWriteOut & ~MemtoRegOut & (WriteRegOut!=0) & (WriteRegOut==RsEX); ForwardBMatch SHALL be the same using RtEX.
REQ-016 Without FORWARD_EN, the forwarding ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-017 Plain load: ValidIn=1, ALUResultIn=0x00001234, WriteRegIn=8, RegWriteIn=1 -> next cycle ALUResultOut=0x00001234, WriteRegOut=8, RegWriteOut=1, ValidOut=1, InstrCount=1.
REQ-018 BEQ taken held by stall: ZeroIn=1, BranchEQIn=1, BranchTargetIn=0x00400020, then Stall=1 for 3 cycles -> PCSrc=1 for exactly one cycle, BranchTargetOut=0x00400020 held, InstrCount unchanged during stall.
REQ-019 Flush with stall: Stall=1 and Flush=1 together while a SW (MemWriteOut=1) is held -> next cycle ValidOut=0, MemWriteOut=0, PCSrc=0.
REQ-020 $zero and illegal controls: WriteRegIn=0 with RegWriteIn=1 -> RegWriteOut=0; MemReadIn=MemWriteIn=1 -> MemReadOut=1, MemWriteOut=0.
REQ-021 Counter wrap and reset: InstrCount preset to 0xFFFFFFFF plus one valid load -> 0; reset=1 asserted mid-branch-stall -> all outputs 0 next cycle and PCSrc never pulses.
REQ-022 FORWARD_EN build: WriteRegOut=9, RegWriteOut=1, RsEX=9, RtEX=9 -> ForwardAMatch=1 and ForwardBMatch=1; setting MemtoRegOut=1 -> both 0.
